// File: rtl/oflow_core_pe_load_scheduler.sv
// oflow_core_pe_load_scheduler: walks one frame's bbox groups from the MEM buffer into the PE array.
module oflow_core_pe_load_scheduler #(
  parameter int PE_NUM = 24,
  parameter int NUM_OF_BBOX_IN_FRAME_WIDTH = 10,
  parameter int ROW_LEN = 6,
  parameter int PE_LEN = 3
) (
  input  logic                                  clk,
  input  logic                                  reset_N,
  input  logic                                  start_write,
  input  logic [NUM_OF_BBOX_IN_FRAME_WIDTH-1:0] num_of_bbox_in_frame,
  output logic                                  buf_req,
  input  logic                                  buf_ack,
  output logic [ROW_LEN-1:0]                    row_sel,
  output logic [PE_LEN-1:0]                     pe_sel,
  output logic [1:0]                            remainder,
  output logic                                  pe_wr_en,
  output logic                                  busy,
  output logic                                  done
);
  localparam int W = NUM_OF_BBOX_IN_FRAME_WIDTH;
  localparam int GW = W - 1;
  typedef enum logic [1:0] {IDLE, REQ, WRITE, DONE} state_t;
  state_t state, state_nx;
  logic [GW-1:0] g, g_last;
  logic [1:0] rem;
  logic [ROW_LEN-1:0] row;
  logic [PE_LEN-1:0] pe;
  logic [W:0] groups;
  logic last;
  assign groups = ({1'b0, num_of_bbox_in_frame} + (W+1)'(3)) >> 2;
  assign last = g == g_last;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  state_nx = start_write ? (num_of_bbox_in_frame == '0 ? DONE : REQ) : IDLE;
      REQ:   state_nx = buf_ack ? WRITE : REQ;
      WRITE: state_nx = last ? DONE : REQ;
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      state  <= IDLE;
      g      <= '0;
      g_last <= '0;
      rem    <= '0;
      row    <= '0;
      pe     <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && start_write) begin
        g      <= '0;
        g_last <= GW'(groups - (W+1)'(1));
        rem    <= num_of_bbox_in_frame[1:0];
        row    <= '0;
        pe     <= '0;
      end else if (state == WRITE && !last) begin
        g   <= g + GW'(1);
        pe  <= pe == PE_LEN'(PE_NUM/4 - 1) ? '0 : pe + PE_LEN'(1);
        row <= pe == PE_LEN'(PE_NUM/4 - 1) ? row + ROW_LEN'(1) : row;
      end
    end
  end
  assign buf_req   = state == REQ;
  assign pe_wr_en  = state == WRITE;
  assign busy      = state != IDLE;
  assign done      = state == DONE;
  assign remainder = (buf_req || pe_wr_en) && last ? rem : 2'd0;
  assign row_sel   = busy ? row : '0;
  assign pe_sel    = busy ? pe : '0;
endmodule

// File: tb/tb_oflow_core_pe_load_scheduler.sv
// tb_oflow_core_pe_load_scheduler: trace-based reference model with random ack delays and stray inputs.
module tb_oflow_core_pe_load_scheduler;
  localparam int PE_NUM = 24;
  localparam int W = 10;
  localparam int RL = 6;
  localparam int PL = 3;
  localparam int GPR = PE_NUM / 4;
  logic clk = 0, reset_N = 0, start_write = 0, buf_ack = 0;
  logic [W-1:0] num = '0;
  logic buf_req, pe_wr_en, busy, done;
  logic [RL-1:0] row_sel;
  logic [PL-1:0] pe_sel;
  logic [1:0] remainder;
  logic [14:0] obs;
  logic [14:0] exp_q[$];
  logic ack_q[$];
  int n_pass = 0, n_chk = 0;

  oflow_core_pe_load_scheduler #(.PE_NUM(PE_NUM), .NUM_OF_BBOX_IN_FRAME_WIDTH(W),
    .ROW_LEN(RL), .PE_LEN(PL)) dut (
    .clk(clk), .reset_N(reset_N), .start_write(start_write),
    .num_of_bbox_in_frame(num), .buf_req(buf_req), .buf_ack(buf_ack),
    .row_sel(row_sel), .pe_sel(pe_sel), .remainder(remainder),
    .pe_wr_en(pe_wr_en), .busy(busy), .done(done));

  always #5 clk = ~clk;
  assign obs = {buf_req, pe_wr_en, busy, done, remainder, row_sel, pe_sel};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_chk++;
    if (got === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, expv);
  endtask

  function automatic logic [14:0] pk(input bit req, wr, bsy, dn, input int rm, row, pe);
    return {req, wr, bsy, dn, 2'(rm), RL'(row), PL'(pe)};
  endfunction

  // Expected per-cycle outputs and the ack to drive in that cycle, from the group walk rules.
  task automatic build(input int n, input int mind, input int maxd);
    int groups, rm, d, lr, lp;
    exp_q.delete();
    ack_q.delete();
    groups = (n + 3) / 4;
    lr = 0;
    lp = 0;
    for (int i = 0; i < groups; i++) begin
      rm = (i == groups - 1) ? n % 4 : 0;
      lr = i / GPR;
      lp = i % GPR;
      d = $urandom_range(maxd, mind);
      for (int j = 0; j <= d; j++) begin
        exp_q.push_back(pk(1, 0, 1, 0, rm, lr, lp));
        ack_q.push_back(j == d);
      end
      exp_q.push_back(pk(0, 1, 1, 0, rm, lr, lp));
      ack_q.push_back(1'($urandom_range(1, 0)));
    end
    exp_q.push_back(pk(0, 0, 1, 1, 0, lr, lp));
    ack_q.push_back(1'($urandom_range(1, 0)));
    exp_q.push_back(pk(0, 0, 0, 0, 0, 0, 0));
    ack_q.push_back(1'($urandom_range(1, 0)));
  endtask

  task automatic run(input string tag, input int n, input int mind, input int maxd, input int abort_at);
    build(n, mind, maxd);
    @(negedge clk);
    start_write = 1;
    num = W'(n);
    buf_ack = 1'($urandom_range(1, 0));
    @(posedge clk);
    for (int c = 0; c < exp_q.size(); c++) begin
      @(negedge clk);
      chk($sformatf("%s n=%0d c%0d", tag, n, c), 32'(obs), 32'(exp_q[c]));
      if (c == abort_at) begin
        reset_N = 0;
        #1 chk($sformatf("%s async reset", tag), 32'(obs), 32'd0);
        @(negedge clk);
        chk($sformatf("%s held reset", tag), 32'(obs), 32'd0);
        reset_N = 1;
        start_write = 0;
        @(negedge clk);
        chk($sformatf("%s after reset", tag), 32'(obs), 32'd0);
        return;
      end
      buf_ack = ack_q[c];
      start_write = (c < exp_q.size() - 1) ? 1'($urandom_range(1, 0)) : 1'b0;
      num = W'($urandom);
      @(posedge clk);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset", 32'(obs), 32'd0);
    reset_N = 1;
    run("n8", 8, 0, 0, -1);
    run("n26", 26, 0, 0, -1);
    run("n0", 0, 0, 0, -1);
    run("n5_d3", 5, 3, 3, -1);
    run("n24_rst", 24, 0, 0, 4);
    run("n4", 4, 0, 0, -1);
    run("n1023", 1023, 0, 1, -1);
    run("n1020", 1020, 0, 0, -1);
    for (int k = 0; k < 25; k++)
      run("rand", int'($urandom_range(200, 0)), 0, 3, -1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
